// File: rtl/mem_arbiter_2p.sv
// Two-client main-memory arbiter: round-robin between the I-cache (client 0) and
// the D-cache (client 1), writeback before fill, registered one-cycle acks.

module mem_arbiter_2p_port #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wack_set_i,
  input  logic             rack_set_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic             write_ack_o,
  output logic             read_ack_o,
  output logic [WIDTH-1:0] read_data_o
);
  logic             wack_q, rack_q;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  assign rdata_d = rack_set_i ? mem_rdata_i : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wack_q  <= 1'b0;
      rack_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      wack_q  <= wack_set_i;
      rack_q  <= rack_set_i;
      rdata_q <= rdata_d;
    end
  end

  assign write_ack_o = wack_q;
  assign read_ack_o  = rack_q;
  assign read_data_o = rdata_q;
endmodule

module mem_arbiter_2p #(
  parameter int WIDTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_write_req,
  input  logic [ADDR_W-1:0] c0_write_addr,
  input  logic [WIDTH-1:0]  c0_write_data,
  output logic              c0_write_ack,
  input  logic              c0_read_req,
  input  logic [ADDR_W-1:0] c0_read_addr,
  output logic [WIDTH-1:0]  c0_read_data,
  output logic              c0_read_ack,
  input  logic              c1_write_req,
  input  logic [ADDR_W-1:0] c1_write_addr,
  input  logic [WIDTH-1:0]  c1_write_data,
  output logic              c1_write_ack,
  input  logic              c1_read_req,
  input  logic [ADDR_W-1:0] c1_read_addr,
  output logic [WIDTH-1:0]  c1_read_data,
  output logic              c1_read_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              grant,
  output logic              busy
);
  localparam int NUM_CLI = 2;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RELEASE} state_e;

  logic [NUM_CLI-1:0]             wr_req, rd_req, cli_req;
  logic [NUM_CLI-1:0][ADDR_W-1:0] wr_addr, rd_addr;
  logic [NUM_CLI-1:0][WIDTH-1:0]  wr_data, rd_data;
  logic [NUM_CLI-1:0]             wack_set, rack_set, wack, rack;
  logic                           sel;

  state_e              state_q, state_d;
  logic                grant_q, grant_d, rr_q, rr_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

  assign wr_req  = {c1_write_req, c0_write_req};
  assign rd_req  = {c1_read_req, c0_read_req};
  assign wr_addr = {c1_write_addr, c0_write_addr};
  assign rd_addr = {c1_read_addr, c0_read_addr};
  assign wr_data = {c1_write_data, c0_write_data};
  assign cli_req = wr_req | rd_req;

  // rr_ptr only breaks ties; a lone requester always wins.
  assign sel = (&cli_req) ? rr_q : cli_req[1];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wack_set    = '0;
    rack_set    = '0;
    case (state_q)
      S_IDLE: begin
        if (|cli_req) begin
          grant_d   = sel;
          mem_req_d = 1'b1;
          if (wr_req[sel]) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr[sel];
            mem_wdata_d = wr_data[sel];
          end else begin
            state_d    = S_READ;
            mem_we_d   = 1'b0;
            mem_addr_d = rd_addr[sel];
          end
        end
      end
      S_WRITE: begin
        if (mem_ack && mem_req_q) begin
          wack_set[grant_q] = 1'b1;
          mem_req_d         = 1'b0;
          if (rd_req[grant_q]) begin
            // Grant stays locked so the evict+fill pair is atomic.
            state_d    = S_READ;
            mem_we_d   = 1'b0;
            mem_addr_d = rd_addr[grant_q];
          end else begin
            state_d = S_RELEASE;
          end
        end
      end
      S_READ: begin
        // Entered from WRITE with mem_req low: re-raise it for the fill.
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          rack_set[grant_q] = 1'b1;
          mem_req_d         = 1'b0;
          state_d           = S_RELEASE;
        end
      end
      S_RELEASE: begin
        rr_d    = ~grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      rr_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  for (genvar g = 0; g < NUM_CLI; g++) begin : g_port
    mem_arbiter_2p_port #(.WIDTH(WIDTH)) u_port (
      .clk        (clk),
      .reset      (reset),
      .wack_set_i (wack_set[g]),
      .rack_set_i (rack_set[g]),
      .mem_rdata_i(mem_rdata),
      .write_ack_o(wack[g]),
      .read_ack_o (rack[g]),
      .read_data_o(rd_data[g])
    );
  end

  assign c0_write_ack = wack[0];
  assign c1_write_ack = wack[1];
  assign c0_read_ack  = rack[0];
  assign c1_read_ack  = rack[1];
  assign c0_read_data = rd_data[0];
  assign c1_read_data = rd_data[1];
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign grant        = grant_q;
  assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Bench for mem_arbiter_2p: directed scenarios plus random rounds scored against
// a transaction-order model and a behavioural memory with variable latency.

module tb_mem_arbiter_2p;
  localparam int W = 128;
  localparam int A = 32;

  typedef struct {
    logic         we;
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } op_t;

  logic clk = 1'b0;
  logic reset;
  logic c0_write_req, c0_write_ack, c0_read_req, c0_read_ack;
  logic c1_write_req, c1_write_ack, c1_read_req, c1_read_ack;
  logic [A-1:0] c0_write_addr, c0_read_addr, c1_write_addr, c1_read_addr;
  logic [W-1:0] c0_write_data, c0_read_data, c1_write_data, c1_read_data;
  logic mem_req, mem_we, mem_ack, grant, busy;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata, mem_rdata;

  mem_arbiter_2p #(.WIDTH(W), .ADDR_W(A)) dut (
    .clk(clk), .reset(reset),
    .c0_write_req(c0_write_req), .c0_write_addr(c0_write_addr), .c0_write_data(c0_write_data),
    .c0_write_ack(c0_write_ack), .c0_read_req(c0_read_req), .c0_read_addr(c0_read_addr),
    .c0_read_data(c0_read_data), .c0_read_ack(c0_read_ack),
    .c1_write_req(c1_write_req), .c1_write_addr(c1_write_addr), .c1_write_data(c1_write_data),
    .c1_write_ack(c1_write_ack), .c1_read_req(c1_read_req), .c1_read_addr(c1_read_addr),
    .c1_read_data(c1_read_data), .c1_read_ack(c1_read_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model state
  op_t          log_q[$];
  logic [W-1:0] mem_arr[logic [A-1:0]];
  int           mem_delay = 0;
  bit           spur_req = 0;
  int           unstable = 0;
  int           last_hold = 0;
  bit           mm_active = 0;
  int           mm_cnt = 0;
  int           mm_hold = 0;
  logic         snap_we;
  logic [A-1:0] snap_addr;
  logic [W-1:0] snap_wdata;

  // Client-side bookkeeping
  int   ack_q[$];   // 0=w0 1=r0 2=w1 3=r1
  logic gnt_q[$];
  int   reissue0 = 0;
  int   reissue1 = 0;
  op_t  exp_ops[$];
  int   exp_acks[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] fill_pattern(input logic [A-1:0] a);
    return {4{a ^ 32'h9E37_79B9}};
  endfunction

  // Memory: acks mem_delay negedges after it first sees mem_req, logs each op.
  initial begin : mem_model
    op_t op;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset) begin
        mm_active = 0;
      end else if (spur_req) begin
        spur_req  = 0;
        mem_ack   = 1'b1;
        mem_rdata = {4{32'hBAD0_0BAD}};
      end else if (mem_req) begin
        if (!mm_active) begin
          mm_active  = 1;
          mm_cnt     = mem_delay;
          mm_hold    = 1;
          snap_we    = mem_we;
          snap_addr  = mem_addr;
          snap_wdata = mem_wdata;
        end else begin
          mm_hold++;
          if (mem_we !== snap_we || mem_addr !== snap_addr || (snap_we && mem_wdata !== snap_wdata))
            unstable++;
          if (mm_cnt > 0) mm_cnt--;
        end
        if (mm_cnt == 0) begin
          op.we   = mem_we;
          op.addr = mem_addr;
          if (mem_we) begin
            op.data = mem_wdata;
            mem_arr[mem_addr] = mem_wdata;
          end else begin
            op.data   = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : fill_pattern(mem_addr);
            mem_rdata = op.data;
          end
          log_q.push_back(op);
          last_hold = mm_hold;
          mem_ack   = 1'b1;
          mm_active = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    c0_write_req = 0; c0_read_req = 0; c1_write_req = 0; c1_read_req = 0;
    c0_write_addr = '0; c0_read_addr = '0; c1_write_addr = '0; c1_read_addr = '0;
    c0_write_data = '0; c1_write_data = '0;
  endtask

  task automatic clear_logs();
    log_q.delete(); ack_q.delete(); gnt_q.delete(); exp_ops.delete(); exp_acks.delete();
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // Clients drop each req on its ack (or reissue a read); runs until all quiet.
  task automatic serve(input int budget);
    int   n = 0;
    bit   done = 0;
    logic [W-1:0] prev0, prev1, last_rd;
    prev0 = c0_read_data;
    prev1 = c1_read_data;
    while (!done && n < budget) begin
      tick();
      n++;
      last_rd = (log_q.size() > 0) ? log_q[log_q.size()-1].data : '0;
      if (c0_write_ack | c0_read_ack | c1_write_ack | c1_read_ack)
        chk("one_ack", W'($countones({c0_write_ack, c0_read_ack, c1_write_ack, c1_read_ack})), 1);
      if (c0_write_ack) begin ack_q.push_back(0); gnt_q.push_back(grant); c0_write_req = 0; end
      if (c1_write_ack) begin ack_q.push_back(2); gnt_q.push_back(grant); c1_write_req = 0; end
      if (c0_read_ack) begin
        ack_q.push_back(1); gnt_q.push_back(grant);
        chk("rdata0", c0_read_data, last_rd);
        if (reissue0 > 0) begin reissue0--; c0_read_addr = c0_read_addr + 32'h10; end
        else c0_read_req = 0;
      end else chk("rdata0_hold", c0_read_data, prev0);
      if (c1_read_ack) begin
        ack_q.push_back(3); gnt_q.push_back(grant);
        chk("rdata1", c1_read_data, last_rd);
        if (reissue1 > 0) begin reissue1--; c1_read_addr = c1_read_addr + 32'h10; end
        else c1_read_req = 0;
      end else chk("rdata1_hold", c1_read_data, prev1);
      prev0 = c0_read_data;
      prev1 = c1_read_data;
      done = !(c0_write_req | c0_read_req | c1_write_req | c1_read_req) && !busy;
    end
    chk("serve_timeout", W'(done), 1);
  endtask

  task automatic check_expected(input string tag);
    chk({tag, "_nacks"}, W'(ack_q.size()), W'(exp_acks.size()));
    for (int i = 0; i < ack_q.size() && i < exp_acks.size(); i++)
      chk({tag, "_ack_order"}, W'(ack_q[i]), W'(exp_acks[i]));
    chk({tag, "_nops"}, W'(log_q.size()), W'(exp_ops.size()));
    for (int i = 0; i < log_q.size() && i < exp_ops.size(); i++) begin
      chk({tag, "_op_we"}, W'(log_q[i].we), W'(exp_ops[i].we));
      chk({tag, "_op_addr"}, W'(log_q[i].addr), W'(exp_ops[i].addr));
      if (exp_ops[i].we) chk({tag, "_op_wdata"}, log_q[i].data, exp_ops[i].data);
    end
  endtask

  task automatic expect_client(input int c, input int t, input logic [A-1:0] wa,
                               input logic [W-1:0] wd, input logic [A-1:0] ra);
    op_t o;
    if (t[1]) begin
      o.we = 1; o.addr = wa; o.data = wd;
      exp_ops.push_back(o); exp_acks.push_back(2*c);
    end
    if (t[0]) begin
      o.we = 0; o.addr = ra; o.data = '0;
      exp_ops.push_back(o); exp_acks.push_back(2*c+1);
    end
  endtask

  initial begin : main
    logic [W-1:0] d0, d1, wd;
    int           nlog;
    int           exp_rr, t0, t1, first;
    logic [A-1:0] wa0, ra0, wa1, ra1;
    logic [W-1:0] wd0, wd1;

    clear_reqs();
    reset = 1;
    repeat (3) tick();
    chk("rst_mem_req", W'(mem_req), 0);
    chk("rst_mem_we", W'(mem_we), 0);
    chk("rst_mem_addr", W'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_grant", W'(grant), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_acks", W'({c0_write_ack, c0_read_ack, c1_write_ack, c1_read_ack}), 0);
    chk("rst_rdata0", c0_read_data, 0);
    chk("rst_rdata1", c1_read_data, 0);
    reset = 0;
    tick();

    // Single fill from client 1
    clear_logs();
    mem_arr[32'h0000_1040] = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
    mem_delay    = 3;
    c1_read_addr = 32'h0000_1040;
    c1_read_req  = 1;
    tick();
    chk("fill_mem_req", W'(mem_req), 1);
    chk("fill_mem_we", W'(mem_we), 0);
    chk("fill_mem_addr", W'(mem_addr), 32'h0000_1040);
    chk("fill_grant", W'(grant), 1);
    begin
      int n = 0;
      while (!c1_read_ack && n < 30) begin tick(); n++; end
    end
    chk("fill_ack", W'(c1_read_ack), 1);
    chk("fill_rdata", c1_read_data, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    chk("fill_release_busy", W'(busy), 1);
    chk("fill_release_req", W'(mem_req), 0);
    c1_read_req = 0;
    tick();
    chk("fill_ack_pulse", W'(c1_read_ack), 0);
    chk("fill_idle", W'(busy), 0);
    chk("fill_nops", W'(log_q.size()), 1);
    chk("fill_c0_quiet", W'({c0_write_ack, c0_read_ack}), 0);

    // Evict+fill on client 1 stays atomic while client 0 waits
    clear_logs();
    mem_delay     = 2;
    c1_write_addr = 32'h0000_2000;
    c1_write_data = {16{8'hA5}};
    c1_read_addr  = 32'h0000_3000;
    c1_write_req  = 1;
    c1_read_req   = 1;
    tick();
    c0_read_addr  = 32'h0000_4000;
    c0_read_req   = 1;
    expect_client(1, 3, 32'h0000_2000, {16{8'hA5}}, 32'h0000_3000);
    expect_client(0, 1, '0, '0, 32'h0000_4000);
    serve(300);
    check_expected("evict");

    // Round-robin from reset with continuous re-requests
    do_reset();
    clear_logs();
    mem_delay    = 1;
    reissue0     = 2;
    reissue1     = 2;
    c0_read_addr = 32'h0000_5000;
    c1_read_addr = 32'h0000_6000;
    c0_read_req  = 1;
    c1_read_req  = 1;
    serve(500);
    chk("rr_n", W'(gnt_q.size()), 6);
    for (int i = 0; i < 6 && i < gnt_q.size(); i++) begin
      chk("rr_grant", W'(gnt_q[i]), W'(i % 2));
      if (i < log_q.size())
        chk("rr_addr", W'(log_q[i].addr), W'(((i % 2) ? 32'h6000 : 32'h5000) + (i / 2) * 16));
    end

    // Spurious mem_ack while idle
    d0   = c0_read_data;
    d1   = c1_read_data;
    nlog = log_q.size();
    spur_req = 1;
    repeat (3) begin
      tick();
      chk("spur_acks", W'({c0_write_ack, c0_read_ack, c1_write_ack, c1_read_ack}), 0);
      chk("spur_busy", W'(busy), 0);
      chk("spur_rdata0", c0_read_data, d0);
      chk("spur_rdata1", c1_read_data, d1);
    end
    chk("spur_nolog", W'(log_q.size()), W'(nlog));

    // Reset while waiting in READ, then the held request is served
    clear_logs();
    mem_delay    = 50;
    c0_read_addr = 32'h0000_8000;
    c0_read_req  = 1;
    repeat (3) tick();
    chk("rmid_busy", W'(busy), 1);
    chk("rmid_req", W'(mem_req), 1);
    reset = 1;
    tick();
    chk("rmid_req_off", W'(mem_req), 0);
    chk("rmid_busy_off", W'(busy), 0);
    chk("rmid_acks", W'({c0_write_ack, c0_read_ack, c1_write_ack, c1_read_ack}), 0);
    reset = 0;
    mem_delay = 2;
    expect_client(0, 1, '0, '0, 32'h0000_8000);
    serve(200);
    check_expected("rmid");

    // Back-pressure: 20-cycle memory stall on a writeback
    clear_logs();
    mem_delay     = 20;
    unstable      = 0;
    wd            = {$urandom, $urandom, $urandom, $urandom};
    c0_write_addr = 32'h0000_7000;
    c0_write_data = wd;
    c0_write_req  = 1;
    expect_client(0, 2, 32'h0000_7000, wd, '0);
    serve(300);
    check_expected("bp");
    chk("bp_stable", W'(unstable), 0);
    chk("bp_hold", W'(last_hold), 21);

    // Random rounds against the ordering model
    do_reset();
    exp_rr = 0;
    for (int r = 0; r < 25; r++) begin
      clear_logs();
      unstable  = 0;
      t0 = $urandom_range(0, 3);
      t1 = $urandom_range(0, 3);
      if (t0 == 0 && t1 == 0) t0 = 1;
      mem_delay = $urandom_range(0, 4);
      wa0 = $urandom & ~32'hF; ra0 = $urandom & ~32'hF;
      wa1 = $urandom & ~32'hF; ra1 = $urandom & ~32'hF;
      wd0 = {$urandom, $urandom, $urandom, $urandom};
      wd1 = {$urandom, $urandom, $urandom, $urandom};
      if (t0 != 0 && t1 != 0) first = exp_rr;
      else first = (t0 != 0) ? 0 : 1;
      if (first == 0) begin
        expect_client(0, t0, wa0, wd0, ra0);
        expect_client(1, t1, wa1, wd1, ra1);
      end else begin
        expect_client(1, t1, wa1, wd1, ra1);
        expect_client(0, t0, wa0, wd0, ra0);
      end
      exp_rr = (t0 != 0 && t1 != 0) ? first : 1 - first;
      c0_write_addr = wa0; c0_write_data = wd0; c0_read_addr = ra0;
      c1_write_addr = wa1; c1_write_data = wd1; c1_read_addr = ra1;
      c0_write_req = t0[1]; c0_read_req = t0[0];
      c1_write_req = t1[1]; c1_read_req = t1[0];
      serve(600);
      check_expected("rnd");
      chk("rnd_stable", W'(unstable), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_2p.md
Name: mem_arbiter_2p

Overview:
- Shares one line-wide main-memory port between two cache clients: client 0 is the instruction cache and client 1 is the data cache.
- Each client presents the same split write/read request channels that a cache_2way instance drives:
  - write channel: req/addr/data/ack
  - read channel: req/addr/data/ack
- The arbiter picks one client with round-robin, serves that client's writeback before its fill, and returns one-cycle ack pulses.
- It sits between the two L1 caches and the memory model or controller.

Parameters:
- WIDTH, 128, bits per cache line / memory word transferred.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- reset  in  1  sync reset
- cN_write_req  in  1  client N (N=0,1) writeback request, level, held until ack
- cN_write_addr  in  ADDR_W  writeback line address
- cN_write_data  in  WIDTH  writeback line data
- cN_write_ack  out  1  one-cycle pulse, write accepted by memory
- cN_read_req  in  1  client N fill request, level, held until ack
- cN_read_addr  in  ADDR_W  fill address
- cN_read_data  out  WIDTH  fill data, valid in the ack cycle and held afterwards
- cN_read_ack  out  1  one-cycle pulse, fill data valid
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse from memory
- grant  out  1  client currently or last owning the port (0/1)
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state=IDLE, rr_ptr=0 (client 0 preferred first).
- States: IDLE, WRITE, READ, RELEASE.
- IDLE arbitration:
  - A client is requesting when cN_write_req | cN_read_req.
  - One requesting client: grant it.
  - Both requesting: grant the client rr_ptr points to.
  - Inside the granted client, the write channel has priority.
  - Go to WRITE if write_req, else READ.
  - On entry, register mem_addr/mem_wdata/mem_we from the granted channel and set mem_req=1.
- Latency: request seen at edge k -> mem_req high after edge k (earliest 1 cycle).
- WRITE:
  - Hold mem_req/mem_we=1/addr/data stable until mem_ack.
  - On mem_ack: pulse cG_write_ack for exactly 1 cycle, drop mem_req.
  - Go to READ if cG_read_req is sampled high in the mem_ack cycle (grant locked, so the evict+fill pair is atomic); else go to RELEASE.
- READ:
  - mem_we=0, hold mem_req until mem_ack.
  - On mem_ack: latch mem_rdata into cG_read_data, pulse cG_read_ack for 1 cycle, drop mem_req, go to RELEASE.
- RELEASE:
  - One idle cycle so clients can deassert their req after the ack.
  - rr_ptr <= ~grant; go to IDLE.
  - No request is sampled in this cycle.
- The non-granted client's requests stay pending. Its acks stay 0 and its read_data is unchanged.
- Acks always come from registers; a read_ack and a write_ack are never high in the same cycle.
- mem_ack arriving in IDLE or RELEASE (spurious) is ignored and no client ack is produced.
- mem_ack in the same cycle as mem_req's first assertion is not possible; the memory samples mem_req registered.
- A client dropping its req mid-transaction is not supported. The transaction completes and the ack is still pulsed.
- Reset mid-transaction: return to IDLE immediately, mem_req=0, no ack issued. The memory must be reset in the same cycle.
- Worst-case wait for a client is one full transaction of the other client (write+read) plus the RELEASE cycles. There is no starvation.
- grant holds its value in IDLE.

Test Plan:
- Single fill: c1_read_req=1, addr 0x0000_1040; memory acks with rdata 0x...DEADBEEF after 3 cycles -> one mem read at 0x1040, c1_read_ack pulses once with c1_read_data=0x...DEADBEEF, then RELEASE, then IDLE.
- Evict+fill: c1 raises write_req (addr 0x2000, data 0xA5..A5) and read_req (0x3000) together, and c0_read_req is also raised -> order is mem write 0x2000, c1_write_ack, mem read 0x3000, c1_read_ack, and only then c0 is served.
- Round-robin: both clients keep re-requesting reads immediately after each ack for 6 transactions -> grant order 0,1,0,1,0,1 from reset.
- Spurious ack: mem_ack pulsed while IDLE -> no cN_*_ack, state stays IDLE, read_data regs unchanged.
- Reset mid-op: assert reset while in READ waiting for mem_ack -> next cycle mem_req=0, busy=0, no ack. After reset releases, a held c0_read_req is served normally.
- Back-pressure: memory delays ack 20 cycles -> mem_addr, mem_we and mem_wdata stay stable every cycle until the ack, and exactly one client ack follows.
